spi_slave_egress_framer: RTL and testbench



---
 rtl/spi_egress_pkg.sv | 29 ++
 rtl/spi_egress_packet_buffer.sv | 47 ++++
 rtl/spi_slave_egress_framer.sv | 150 +++++++++++++++
 tb/tb_spi_slave_egress_framer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_egress_pkg.sv
// Shared types and header helpers for the SPI slave egress framer.
package spi_egress_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HEADER = 2'd1,
    DRAIN  = 2'd2
  } framer_state_t;

  // Header byte layout: {tag[2:0], length[4:0]}
  localparam int HDR_TAG_MSB = 7;
  localparam int HDR_TAG_LSB = 5;
  localparam int HDR_LEN_MSB = 4;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  localparam logic [2:0] HEADER_TAG_DEFAULT = 3'b101;
  localparam logic [7:0] IDLE_BYTE_DEFAULT  = 8'hBC;

  function automatic logic [7:0] make_header(input logic [2:0] tag,
                                             input logic [HDR_LEN_W-1:0] len);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_TAG_MSB:HDR_TAG_LSB] = tag;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/spi_egress_packet_buffer.sv
// Payload storage for one packet: single write port, registered read port.
module spi_egress_packet_buffer import spi_egress_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = HDR_LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [7:0] rdata_q, rdata_d;

  // write port and read mux; out-of-range reads return zero
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr < DEPTH_C)) begin
      mem_d[waddr[IW-1:0]] = wdata;
    end
    rdata_d = (raddr < DEPTH_C) ? mem_q[raddr[IW-1:0]] : 8'h00;
  end

  // storage array carries no reset; contents are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_slave_egress_framer.sv
// Packetizer ahead of the SPI slave egress serializer: buffers readout bytes,
// then emits {tag, length} followed by the payload on an 8-bit AXIS master.
//
// state  | meaning
// FILL   | accepting payload bytes until tlast, MTU, flush or idle timeout
// HEADER | header byte presented, waiting for downstream to take it
// DRAIN  | payload bytes streamed out from the buffer, one per accepted beat
module spi_slave_egress_framer import spi_egress_pkg::*; #(
  parameter int         MTU_SIZE       = 16,
  parameter logic [2:0] HEADER_TAG     = HEADER_TAG_DEFAULT,
  parameter logic [7:0] IDLE_BYTE      = IDLE_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic        flush,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tuser,
  output logic [15:0] packets_sent
);

  localparam int            CW      = HDR_LEN_W;
  localparam int            TW      = 16;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MTU_C   = CW'(MTU_SIZE);
  localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);
  // Timeout fires on the idle edge that would take the timer to TIMEOUT_CYCLES.
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  framer_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   pkts_q, pkts_d;
  logic          s_ready_q, s_ready_d;

  logic          accept;
  logic          last_beat;
  logic          close;
  logic          timed_out;
  logic [CW-1:0] count_acc;
  logic [7:0]    buf_rdata;

  assign accept    = s_axis_tvalid && s_ready_q;
  assign last_beat = (state_q == DRAIN) && (idx_q == (count_q - ONE));

  // next state, byte count, drain index, idle timer and packet counter
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    pkts_d    = pkts_q;
    count_acc = count_q + (accept ? ONE : '0);
    timed_out = 1'b0;
    close     = 1'b0;
    case (state_q)
      FILL: begin
        idx_d   = '0;
        count_d = count_acc;
        if (accept) begin
          timer_d = '0;
        end else if ((count_q != '0) && (timer_q != '1)) begin
          timer_d = timer_q + TW'(1);
        end
        timed_out = TO_EN && !accept && (count_q != '0) && (timer_q == TO_LAST);
        // close uses the post-accept count so a coincident byte joins the packet
        close = (accept && s_axis_tlast) || (count_acc == MTU_C) ||
                (flush && (count_acc != '0)) || timed_out;
        if (close) begin
          state_d = HEADER;
          timer_d = '0;
        end
      end
      HEADER: begin
        idx_d = '0;
        if (m_axis_tready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_axis_tready) begin
          if (last_beat) begin
            state_d = FILL;
            count_d = '0;
            idx_d   = '0;
            timer_d = '0;
            pkts_d  = pkts_q + 16'd1;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    s_ready_d = (state_d == FILL) && (count_d < MTU_C);
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      count_q   <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      pkts_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      pkts_q    <= pkts_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Read address follows the next index so the registered read already holds
  // the byte to present on the cycle after each output transfer.
  spi_egress_packet_buffer #(
    .DEPTH (MTU_SIZE),
    .AW    (CW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (count_q),
    .wdata (s_axis_tdata),
    .raddr (idx_d),
    .rdata (buf_rdata)
  );

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = (state_q != FILL);
  assign m_axis_tlast  = last_beat;
  assign m_axis_tdata  = (state_q == HEADER) ? make_header(HEADER_TAG, count_q) :
                         (state_q == DRAIN)  ? buf_rdata : 8'h00;
  assign m_axis_tuser  = IDLE_BYTE;
  assign packets_sent  = pkts_q;

endmodule

// File: tb/tb_spi_slave_egress_framer.sv
// Bench for spi_slave_egress_framer: directed scenarios plus random traffic
// checked every cycle against a queue-based packet model.
module tb_spi_slave_egress_framer;

  localparam int MTU = 16;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  s_axis_tdata  = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast  = 1'b0;
  logic        flush         = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        s_axis_tready, m_axis_tvalid, m_axis_tlast;
  logic [7:0]  m_axis_tdata, m_axis_tuser;
  logic [15:0] packets_sent;

  logic [7:0]  z_s_axis_tdata  = 8'h00;
  logic        z_s_axis_tvalid = 1'b0;
  logic        z_s_axis_tlast  = 1'b0;
  logic        z_flush         = 1'b0;
  logic        z_m_axis_tready = 1'b1;
  logic        z_s_axis_tready, z_m_axis_tvalid, z_m_axis_tlast;
  logic [7:0]  z_m_axis_tdata, z_m_axis_tuser;
  logic [15:0] z_packets_sent;

  spi_slave_egress_framer dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .flush(flush),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .packets_sent(packets_sent)
  );

  spi_slave_egress_framer #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .rst(rst),
    .s_axis_tdata(z_s_axis_tdata), .s_axis_tvalid(z_s_axis_tvalid),
    .s_axis_tlast(z_s_axis_tlast), .s_axis_tready(z_s_axis_tready),
    .flush(z_flush),
    .m_axis_tdata(z_m_axis_tdata), .m_axis_tvalid(z_m_axis_tvalid),
    .m_axis_tlast(z_m_axis_tlast), .m_axis_tready(z_m_axis_tready),
    .m_axis_tuser(z_m_axis_tuser), .packets_sent(z_packets_sent)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: collected payload, pending output bytes, idle edge count
  logic [7:0] pkt[$];
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  bit         last_log[$];
  logic [7:0] exp_l[$];
  bit         busy = 1'b0;
  bit         m_rdy = 1'b0;
  bit         last_accept = 1'b0;
  int         idle = 0;
  int         pkts = 0;
  int         z_seen = 0;
  logic [7:0] z_log[$];
  bit         z_last_log[$];

  task automatic model_step();
    bit acc;
    bit close;
    check("s_tready", s_axis_tready, m_rdy);
    check("m_tvalid", m_axis_tvalid, busy);
    check("m_tuser", m_axis_tuser, 8'hBC);
    check("pkts_sent", packets_sent, pkts & 16'hFFFF);
    if (busy && exp_q.size() > 0) begin
      check("m_tdata", m_axis_tdata, exp_q[0]);
      check("m_tlast", m_axis_tlast, exp_q.size() == 1);
    end else begin
      check("m_tlast_idle", m_axis_tlast, 0);
    end
    if (z_m_axis_tvalid) z_seen++;
    if (z_m_axis_tvalid && z_m_axis_tready) begin
      z_log.push_back(z_m_axis_tdata);
      z_last_log.push_back(z_m_axis_tlast);
    end
    last_accept = 1'b0;
    if (rst) begin
      pkt.delete();
      exp_q.delete();
      busy = 1'b0;
      idle = 0;
      pkts = 0;
    end else if (busy) begin
      if (m_axis_tready && exp_q.size() > 0) begin
        log_q.push_back(m_axis_tdata);
        last_log.push_back(m_axis_tlast);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          busy = 1'b0;
          pkts++;
        end
      end
    end else begin
      acc = s_axis_tvalid && m_rdy;
      last_accept = acc;
      if (acc) begin
        pkt.push_back(s_axis_tdata);
        idle = 0;
      end else if (pkt.size() > 0) begin
        idle++;
      end
      close = (pkt.size() > 0) &&
              ((acc && s_axis_tlast) || (pkt.size() == MTU) || flush || (TO > 0 && idle == TO));
      if (close) begin
        exp_q.delete();
        exp_q.push_back({3'b101, 5'(pkt.size())});
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
        pkt.delete();
        idle = 0;
        busy = 1'b1;
      end
    end
    m_rdy = !rst && !busy && (pkt.size() < MTU);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    do begin
      cycle();
      n++;
    end while (!last_accept && n < 200);
    if (!last_accept) check("send_bound", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || pkt.size() != 0) && n < 500) begin
      cycle();
      n++;
    end
    if (busy || pkt.size() != 0) check("idle_bound", 0, 1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_l.size());
    for (int i = 0; i < exp_l.size(); i++) begin
      check(tag, (i < log_q.size()) ? {24'h0, log_q[i]} : 32'hFFFF_FFFF, exp_l[i]);
    end
  endtask

  initial begin
    int pct;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_tready", s_axis_tready, 0);
    check("rst_pkts", packets_sent, 0);
    check("rst_tuser", m_axis_tuser, 8'hBC);
    check("rst_nt_tready", z_s_axis_tready, 0);
    rst = 1'b0;

    // single byte packet
    log_q.delete(); last_log.delete();
    m_axis_tready = 1'b1;
    send_byte(8'h5A, 1'b1);
    wait_idle();
    exp_l.delete(); exp_l.push_back(8'hA1); exp_l.push_back(8'h5A);
    check_log("single");
    if (last_log.size() == 2) check("single_tlast", last_log[1], 1);
    else check("single_tlast_len", last_log.size(), 2);
    check("single_pkts", packets_sent, 1);

    // MTU fill followed by a timeout flush of the remainder
    log_q.delete(); last_log.delete();
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
    wait_idle();
    exp_l.delete();
    exp_l.push_back(8'hB0);
    for (int i = 0; i < 16; i++) exp_l.push_back(8'(i));
    exp_l.push_back(8'hA4);
    for (int i = 16; i < 20; i++) exp_l.push_back(8'(i));
    check_log("mtu");
    if (last_log.size() == 22) begin
      check("mtu_tlast1", last_log[16], 1);
      check("mtu_tlast2", last_log[21], 1);
    end
    check("mtu_pkts", packets_sent, 3);

    // backpressure 1,0,0,1 on a 3-byte packet
    log_q.delete(); last_log.delete();
    m_axis_tready = 1'b0;
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b1);
    for (int k = 0; k < 8; k++) begin
      m_axis_tready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      cycle();
    end
    m_axis_tready = 1'b1;
    wait_idle();
    exp_l.delete();
    exp_l.push_back(8'hA3); exp_l.push_back(8'h31); exp_l.push_back(8'h32); exp_l.push_back(8'h33);
    check_log("bp");

    // flush while empty is ignored
    log_q.delete(); last_log.delete();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();
    check("flush_empty_len", log_q.size(), 0);
    check("flush_empty_valid", m_axis_tvalid, 0);

    // flush coincident with an accepted byte
    send_byte(8'h66, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h77;
    flush         = 1'b1;
    cycle();
    check("flush_acc", last_accept, 1);
    flush = 1'b0;
    s_axis_tvalid = 1'b0;
    wait_idle();
    exp_l.delete();
    exp_l.push_back(8'hA2); exp_l.push_back(8'h66); exp_l.push_back(8'h77);
    check_log("flush_coinc");

    // random traffic with varying input density
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: pct = 90;
        1: pct = 50;
        2: pct = 10;
        default: pct = 2;
      endcase
      for (int c = 0; c < 400; c++) begin
        if (!s_axis_tvalid || last_accept) begin
          s_axis_tvalid = ($urandom_range(99) < pct);
          s_axis_tdata  = 8'($urandom);
          s_axis_tlast  = ($urandom_range(7) == 0);
        end
        flush         = ($urandom_range(60) == 0);
        m_axis_tready = ($urandom_range(3) != 0);
        cycle();
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    flush         = 1'b0;
    m_axis_tready = 1'b1;
    wait_idle();

    // reset in the middle of a drain
    log_q.delete(); last_log.delete();
    m_axis_tready = 1'b0;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b1);
    m_axis_tready = 1'b1;
    cycle();
    cycle();
    check("mid_log_len", log_q.size(), 2);
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", m_axis_tvalid, 0);
    check("mid_rst_pkts", packets_sent, 0);
    check("mid_rst_ready", s_axis_tready, 0);
    rst = 1'b0;
    cycle();
    check("mid_rel_ready", s_axis_tready, 1);
    repeat (5) cycle();
    check("mid_no_more", log_q.size(), 2);

    // timeout disabled build: partial packet waits for flush
    z_seen = 0;
    z_log.delete(); z_last_log.delete();
    check("nt_ready", z_s_axis_tready, 1);
    z_s_axis_tvalid = 1'b1;
    z_s_axis_tdata  = 8'h11;
    cycle();
    z_s_axis_tdata  = 8'h22;
    cycle();
    z_s_axis_tvalid = 1'b0;
    repeat (1000) cycle();
    check("nt_no_out", z_seen, 0);
    z_flush = 1'b1;
    cycle();
    z_flush = 1'b0;
    repeat (10) cycle();
    check("nt_len", z_log.size(), 3);
    if (z_log.size() == 3) begin
      check("nt_hdr", z_log[0], 8'hA2);
      check("nt_b0", z_log[1], 8'h11);
      check("nt_b1", z_log[2], 8'h22);
      check("nt_tlast", z_last_log[2], 1);
    end
    check("nt_pkts", z_packets_sent, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
